// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed 7-segment display driver.
//   - SEG_0 .. SEG_F : active-low glyphs, bit [0] = segment a ... bit [6] = g
//   - SEG_OFF        : every segment dark
//   - scanState_e    : per-slot phase of the scan (blanking gap / digit shown)
//   - clog2()        : counter width helper, never returns less than 1
// ----------------------------------------------------------------------------
package disp_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [0:0] {
        ST_BLANK,
        ST_SHOW
    } scanState_e;

    // Width needed to hold 0..value-1; a 1-value counter still gets one bit
    // so that no zero-width vectors appear anywhere.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-low 7-segment glyph.
//   hex  in  4  value to display
//   segN out 7  segments a..g on [0]..[6], 0 = lit
// All sixteen codes map to a glyph (0-9, A, b, C, d, E, F).
// ----------------------------------------------------------------------------
module seg7_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segN
);

    // Plain lookup from the glyph constants in disp_pkg.
    always_comb begin
        segN = SEG_OFF;
        case (hex)
            4'h0: segN = SEG_0;
            4'h1: segN = SEG_1;
            4'h2: segN = SEG_2;
            4'h3: segN = SEG_3;
            4'h4: segN = SEG_4;
            4'h5: segN = SEG_5;
            4'h6: segN = SEG_6;
            4'h7: segN = SEG_7;
            4'h8: segN = SEG_8;
            4'h9: segN = SEG_9;
            4'hA: segN = SEG_A;
            4'hB: segN = SEG_B;
            4'hC: segN = SEG_C;
            4'hD: segN = SEG_D;
            4'hE: segN = SEG_E;
            4'hF: segN = SEG_F;
        endcase
    end

endmodule

// File: rtl/disp_scan_mux.sv
// ----------------------------------------------------------------------------
// disp_scan_mux
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits that
// share one segment bus. New values are captured into a pending buffer and
// copied into the display shadow only at a frame boundary, so a frame never
// mixes old and new digits. Each digit slot starts with a blanking gap to
// suppress ghosting while the digit enables switch over.
//
// Ports (all display outputs active-low):
//   clk       in   1             system clock
//   rst_n     in   1             asynchronous active-low reset
//   digits_i  in   4*NUM_DIGITS  hex nibble per digit, digit 0 rightmost
//   dp_i      in   NUM_DIGITS    decimal point request per digit (1 = lit)
//   blink_i   in   NUM_DIGITS    per-digit blink request
//   upd_i     in   1             strobe: capture digits_i/dp_i/blink_i
//   upd_ack_o out  1             pulse in the cycle the pending data is taken
//   seg_n     out  7             segments a..g, 0 = lit
//   dp_n      out  1             decimal point, 0 = lit
//   dig_n     out  NUM_DIGITS    digit enables, at most one low
//
// Build option: define DISP_BLINK_EN to honour blink_i. Without it blink_i is
// ignored, there is no frame counter and every digit is always shown.
// ----------------------------------------------------------------------------
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic                    upd_i,
    output logic                    upd_ack_o,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dig_n
);

    localparam int CNT_W = clog2(SCAN_DIV);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slotEnd;
    logic                    frameEnd;

    logic [4*NUM_DIGITS-1:0] pendDigits;
    logic [NUM_DIGITS-1:0]   pendDp;
    logic                    pendV;
    logic [4*NUM_DIGITS-1:0] shadowDigits;
    logic [NUM_DIGITS-1:0]   shadowDp;

    scanState_e              state;
    scanState_e              nextState;
    logic                    hideDigit;
    logic [6:0]              glyph;
    logic [6:0]              nextSegN;
    logic                    nextDpN;
    logic [NUM_DIGITS-1:0]   nextDigN;

    assign slotEnd  = (cnt == CNT_LAST);
    assign frameEnd = slotEnd && (idx == IDX_LAST);

    // Slot timer: one full count is one digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (slotEnd) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit being scanned; its wrap marks the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (frameEnd) begin
            idx <= '0;
        end else if (slotEnd) begin
            idx <= idx + 1'b1;
        end
    end

    // Double buffer. A strobe landing exactly on the boundary bypasses the
    // pending stage; otherwise the latest strobe waits in pending and is
    // copied over at the next boundary. The shadow only ever changes on a
    // boundary edge, which keeps each frame coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendDigits   <= '0;
            pendDp       <= '0;
            pendV        <= 1'b0;
            shadowDigits <= '0;
            shadowDp     <= '0;
        end else if (frameEnd && upd_i) begin
            shadowDigits <= digits_i;
            shadowDp     <= dp_i;
            pendV        <= 1'b0;
        end else if (frameEnd && pendV) begin
            shadowDigits <= pendDigits;
            shadowDp     <= pendDp;
            pendV        <= 1'b0;
        end else if (upd_i) begin
            pendDigits   <= digits_i;
            pendDp       <= dp_i;
            pendV        <= 1'b1;
        end
    end

    // The acknowledge is decoded rather than registered so that it sits in
    // the very cycle whose closing edge performs the copy.
    assign upd_ack_o = frameEnd && (upd_i || pendV);

`ifdef DISP_BLINK_EN
    localparam int FRM_W = clog2(BLINK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] pendBlink;
    logic [NUM_DIGITS-1:0] shadowBlink;
    logic [FRM_W-1:0]      frameCnt;
    logic                  phaseOn;

    // Blink masks follow exactly the same buffering as the digit data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendBlink   <= '0;
            shadowBlink <= '0;
        end else if (frameEnd && upd_i) begin
            shadowBlink <= blink_i;
        end else if (frameEnd && pendV) begin
            shadowBlink <= pendBlink;
        end else if (upd_i) begin
            pendBlink   <= blink_i;
        end
    end

    // Counts whole frames; every BLINK_FRAMES frames the blink phase flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameCnt <= '0;
            phaseOn  <= 1'b1;
        end else if (frameEnd) begin
            if (frameCnt == FRM_LAST) begin
                frameCnt <= '0;
                phaseOn  <= ~phaseOn;
            end else begin
                frameCnt <= frameCnt + 1'b1;
            end
        end
    end

    assign hideDigit = !phaseOn && shadowBlink[idx];
`else
    localparam int unusedBlinkFrames = BLINK_FRAMES;
    logic unusedBlink;

    assign unusedBlink = ^blink_i;
    assign hideDigit   = 1'b0;
`endif

    seg7_hex_decode uDecode (
        .hex  (shadowDigits[4*idx +: 4]),
        .segN (glyph)
    );

    // Scan FSM state register. The state always mirrors whether cnt is past
    // the blanking gap, so transitions are taken one count early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            ST_BLANK: if (cnt == BLANK_LAST) nextState = ST_SHOW;
            ST_SHOW:  if (slotEnd)           nextState = ST_BLANK;
            default:  nextState = ST_BLANK;
        endcase
    end

    // Output decode: everything dark unless showing a digit that is not
    // currently blinked off.
    always_comb begin
        nextSegN = SEG_OFF;
        nextDpN  = 1'b1;
        nextDigN = '1;
        if ((state == ST_SHOW) && !hideDigit) begin
            nextSegN      = glyph;
            nextDpN       = ~shadowDp[idx];
            nextDigN[idx] = 1'b0;
        end
    end

    // Registered pins so the board sees glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
            dig_n <= '1;
        end else begin
            seg_n <= nextSegN;
            dp_n  <= nextDpN;
            dig_n <= nextDigN;
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_disp_scan_mux
// Self-checking bench for disp_scan_mux with a small configuration
// (4 digits, 8-cycle slots, 2-cycle blanking gap, 2-frame blink half-period).
// The reference model derives slot, digit and frame numbers from the cycle
// count since reset, keeps the pending/shadow buffers as plain variables and
// builds glyphs from the list of lit segment letters.
// Define DISP_BLINK_EN for both bench and design to exercise blinking.
// ----------------------------------------------------------------------------
module tb_disp_scan_mux;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = SD * ND;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blink_i = '0;
    logic        upd_i = 1'b0;
    logic        upd_ack_o;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_n;

    int errors;
    int checks;

    int          n;
    logic [15:0] mShDig;
    logic [3:0]  mShDp;
    logic [3:0]  mShBl;
    logic [15:0] mPendDig;
    logic [3:0]  mPendDp;
    logic [3:0]  mPendBl;
    logic        mPendV;

    logic        expAck, obsAck;
    logic [3:0]  expDig, obsDig;
    logic [6:0]  expSeg, obsSeg;
    logic        expDp, obsDp;
    logic        segKnown;

    string glyphLit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    disp_scan_mux #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_i  (digits_i),
        .dp_i      (dp_i),
        .blink_i   (blink_i),
        .upd_i     (upd_i),
        .upd_ack_o (upd_ack_o),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .dig_n     (dig_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyphOf(input logic [3:0] h);
        logic [6:0] g;
        string      s;
        int         b;
        g = 7'h7F;
        s = glyphLit[h];
        for (int i = 0; i < s.len(); i++) begin
            b = int'(s[i]) - 97;
            g[b] = 1'b0;
        end
        return g;
    endfunction

    task automatic modelReset();
        n        = 0;
        mShDig   = '0;
        mShDp    = '0;
        mShBl    = '0;
        mPendDig = '0;
        mPendDp  = '0;
        mPendBl  = '0;
        mPendV   = 1'b0;
    endtask

    // Drives one clock cycle, predicts the outputs that appear after its edge
    // and records the observed values for the calling test to compare.
    task automatic runCycle(input logic upd, input logic [15:0] d,
                            input logic [3:0] p, input logic [3:0] bl);
        int cnt;
        int idx;
        bit boundary;
        bit show;
        bit hidden;
        cnt      = n % SD;
        idx      = (n / SD) % ND;
        boundary = (cnt == SD - 1) && (idx == ND - 1);
        upd_i    = upd;
        digits_i = d;
        dp_i     = p;
        blink_i  = bl;
        #1;
        obsAck = upd_ack_o;
        expAck = boundary && (upd || mPendV);
        show   = (cnt >= BC);
`ifdef DISP_BLINK_EN
        hidden = show && (((n / FRAME) / BF) % 2 == 1) && mShBl[idx];
`else
        hidden = 1'b0;
`endif
        expDig   = 4'hF;
        expSeg   = 7'h7F;
        expDp    = 1'b1;
        segKnown = !hidden;
        if (show && !hidden) begin
            expDig[idx] = 1'b0;
            expSeg      = glyphOf(mShDig[4*idx +: 4]);
            expDp       = ~mShDp[idx];
        end
        if (boundary && upd) begin
            mShDig = d;
            mShDp  = p;
            mShBl  = bl;
            mPendV = 1'b0;
        end else if (boundary && mPendV) begin
            mShDig = mPendDig;
            mShDp  = mPendDp;
            mShBl  = mPendBl;
            mPendV = 1'b0;
        end else if (upd) begin
            mPendDig = d;
            mPendDp  = p;
            mPendBl  = bl;
            mPendV   = 1'b1;
        end
        @(posedge clk);
        #1;
        upd_i  = 1'b0;
        obsDig = dig_n;
        obsSeg = seg_n;
        obsDp  = dp_n;
        n++;
    endtask

    task automatic alignTo(input int phase);
        while ((n % FRAME) != phase) runCycle(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("[TB] FAIL reset seg_n got %h want 7f", seg_n); end
        checks++; if (dig_n !== 4'hF) begin errors++; $display("[TB] FAIL reset dig_n got %b want 1111", dig_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("[TB] FAIL reset dp_n got %b want 1", dp_n); end
        checks++; if (upd_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset ack got %b want 0", upd_ack_o); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        modelReset();
        repeat (20) runCycle(1'b0, 16'h0, 4'h0, 4'h0);
        checks++; if (obsDig !== expDig) begin errors++; $display("[TB] FAIL pre-reset dig_n got %b want %b", obsDig, expDig); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("[TB] FAIL midshow reset seg_n got %h want 7f", seg_n); end
        checks++; if (dig_n !== 4'hF) begin errors++; $display("[TB] FAIL midshow reset dig_n got %b want 1111", dig_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("[TB] FAIL midshow reset dp_n got %b want 1", dp_n); end
        checks++; if (upd_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL midshow reset ack got %b want 0", upd_ack_o); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_scan_order();
        int lowCycles;
        lowCycles = 0;
        alignTo(0);
        for (int i = 0; i < 3 * FRAME; i++) begin
            runCycle(1'b0, 16'h0, 4'h0, 4'h0);
            if (obsDig !== 4'hF) lowCycles++;
            checks++; if (obsDig !== expDig) begin errors++; $display("[TB] FAIL scan dig_n n=%0d got %b want %b", n, obsDig, expDig); end
            checks++; if ($countones(~obsDig) > 1) begin errors++; $display("[TB] FAIL scan onehot n=%0d got %b want at most one low", n, obsDig); end
        end
        checks++; if (lowCycles != (SD - BC) * ND * 3) begin errors++; $display("[TB] FAIL scan duty got %0d want %0d", lowCycles, (SD - BC) * ND * 3); end
    endtask

    task automatic test_update();
        int         ackCount;
        bit         armed;
        logic [6:0] seenSeg0, seenSeg2;
        logic       seenDp2;
        ackCount = 0;
        armed    = 1'b0;
        seenSeg0 = 7'h7F;
        seenSeg2 = 7'h7F;
        seenDp2  = 1'b1;
        alignTo($urandom_range(0, FRAME - 2));
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            if (i == 0) runCycle(1'b1, 16'h12AF, 4'b0100, 4'h0);
            else        runCycle(1'b0, 16'h0, 4'h0, 4'h0);
            if (obsAck) ackCount++;
            checks++; if (obsAck !== expAck) begin errors++; $display("[TB] FAIL update ack n=%0d got %b want %b", n, obsAck, expAck); end
            checks++; if (obsDig !== expDig) begin errors++; $display("[TB] FAIL update dig_n n=%0d got %b want %b", n, obsDig, expDig); end
            checks++; if (obsSeg !== expSeg) begin errors++; $display("[TB] FAIL update seg_n n=%0d got %b want %b", n, obsSeg, expSeg); end
            checks++; if (obsDp !== expDp) begin errors++; $display("[TB] FAIL update dp_n n=%0d got %b want %b", n, obsDp, expDp); end
            if (armed && obsDig == 4'b1110) seenSeg0 = obsSeg;
            if (armed && obsDig == 4'b1011) begin seenSeg2 = obsSeg; seenDp2 = obsDp; end
            if (obsAck) armed = 1'b1;
        end
        checks++; if (ackCount != 1) begin errors++; $display("[TB] FAIL update ack count got %0d want 1", ackCount); end
        checks++; if (seenSeg0 !== 7'b0001110) begin errors++; $display("[TB] FAIL update digit0 glyph got %b want 0001110", seenSeg0); end
        checks++; if (seenSeg2 !== 7'b0100100) begin errors++; $display("[TB] FAIL update digit2 glyph got %b want 0100100", seenSeg2); end
        checks++; if (seenDp2 !== 1'b0) begin errors++; $display("[TB] FAIL update digit2 dp got %b want 0", seenDp2); end
    endtask

    task automatic test_back_to_back();
        int ackCount;
        int badShown;
        bit armed;
        ackCount = 0;
        badShown = 0;
        armed    = 1'b0;
        alignTo(1);
        runCycle(1'b1, 16'h1111, 4'h0, 4'h0);
        repeat (3) begin
            runCycle(1'b0, 16'h0, 4'h0, 4'h0);
            if (obsAck) ackCount++;
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 0) runCycle(1'b1, 16'h2222, 4'h0, 4'h0);
            else        runCycle(1'b0, 16'h0, 4'h0, 4'h0);
            if (obsAck) ackCount++;
            checks++; if (obsAck !== expAck) begin errors++; $display("[TB] FAIL b2b ack n=%0d got %b want %b", n, obsAck, expAck); end
            checks++; if (obsSeg !== expSeg) begin errors++; $display("[TB] FAIL b2b seg_n n=%0d got %b want %b", n, obsSeg, expSeg); end
            if (armed && obsDig !== 4'hF && obsSeg !== 7'b0100100) badShown++;
            if (obsAck) armed = 1'b1;
        end
        checks++; if (ackCount != 1) begin errors++; $display("[TB] FAIL b2b ack count got %0d want 1", ackCount); end
        checks++; if (badShown != 0 || !armed) begin errors++; $display("[TB] FAIL b2b shows-2 got %0d wrong glyphs (acked=%0b) want 0", badShown, armed); end
    endtask

    task automatic test_boundary_update();
        logic [15:0] d;
        logic [3:0]  p;
        logic [6:0]  firstSeg0;
        bit          found;
        d     = 16'($urandom);
        p     = 4'($urandom);
        found = 1'b0;
        firstSeg0 = 7'h7F;
        alignTo(FRAME - 1);
        runCycle(1'b1, d, p, 4'h0);
        checks++; if (obsAck !== 1'b1) begin errors++; $display("[TB] FAIL boundary ack got %b want 1", obsAck); end
        for (int i = 0; i < FRAME + 1; i++) begin
            runCycle(1'b0, 16'h0, 4'h0, 4'h0);
            checks++; if (obsAck !== expAck) begin errors++; $display("[TB] FAIL boundary ack n=%0d got %b want %b", n, obsAck, expAck); end
            checks++; if (obsDig !== expDig) begin errors++; $display("[TB] FAIL boundary dig_n n=%0d got %b want %b", n, obsDig, expDig); end
            checks++; if (obsSeg !== expSeg) begin errors++; $display("[TB] FAIL boundary seg_n n=%0d got %b want %b", n, obsSeg, expSeg); end
            checks++; if (obsDp !== expDp) begin errors++; $display("[TB] FAIL boundary dp_n n=%0d got %b want %b", n, obsDp, expDp); end
            if (!found && obsDig == 4'b1110) begin found = 1'b1; firstSeg0 = obsSeg; end
        end
        checks++; if (firstSeg0 !== glyphOf(d[3:0])) begin errors++; $display("[TB] FAIL boundary slot0 glyph got %b want %b", firstSeg0, glyphOf(d[3:0])); end
    endtask

    task automatic test_random();
        logic upd;
        for (int i = 0; i < 320; i++) begin
            upd = ($urandom_range(0, 7) == 0);
            runCycle(upd, 16'($urandom), 4'($urandom), 4'($urandom));
            checks++; if (obsAck !== expAck) begin errors++; $display("[TB] FAIL random ack n=%0d got %b want %b", n, obsAck, expAck); end
            checks++; if (obsDig !== expDig) begin errors++; $display("[TB] FAIL random dig_n n=%0d got %b want %b", n, obsDig, expDig); end
            if (segKnown) begin
                checks++; if (obsSeg !== expSeg) begin errors++; $display("[TB] FAIL random seg_n n=%0d got %b want %b", n, obsSeg, expSeg); end
                checks++; if (obsDp !== expDp) begin errors++; $display("[TB] FAIL random dp_n n=%0d got %b want %b", n, obsDp, expDp); end
            end
        end
    endtask

`ifdef DISP_BLINK_EN
    task automatic test_blink();
        int  low0;
        int  low1;
        int  window;
        bit  armed;
        low0   = 0;
        low1   = 0;
        window = 0;
        armed  = 1'b0;
        alignTo(0);
        runCycle(1'b1, 16'h4321, 4'h0, 4'b0001);
        for (int i = 0; i < 6 * FRAME; i++) begin
            runCycle(1'b0, 16'h0, 4'h0, 4'h0);
            checks++; if (obsDig !== expDig) begin errors++; $display("[TB] FAIL blink dig_n n=%0d got %b want %b", n, obsDig, expDig); end
            if (armed && window < 4 * FRAME) begin
                window++;
                if (obsDig == 4'b1110) low0++;
                if (obsDig == 4'b1101) low1++;
            end
            if (obsAck) armed = 1'b1;
        end
        checks++; if (low0 != 2 * (SD - BC)) begin errors++; $display("[TB] FAIL blink digit0 lit cycles got %0d want %0d", low0, 2 * (SD - BC)); end
        checks++; if (low1 != 4 * (SD - BC)) begin errors++; $display("[TB] FAIL blink digit1 lit cycles got %0d want %0d", low1, 4 * (SD - BC)); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        modelReset();
        test_reset();
        test_scan_order();
        test_update();
        test_back_to_back();
        test_boundary_update();
        test_random();
`ifdef DISP_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
